// File: rtl/spi_frame_commit_pkg.sv
// Shared constants for the SPI frame sequencer: FSM encoding, frame byte map, default length.
package spi_frame_commit_pkg;

  localparam int NBYTES_DEF = 21;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RECV   = 2'd1;
  localparam logic [1:0] ST_DRAIN  = 2'd2;
  localparam logic [1:0] ST_COMMIT = 2'd3;

  localparam int OFS_VEL0  = 0;
  localparam int OFS_VEL1  = 2;
  localparam int OFS_VEL2  = 4;
  localparam int OFS_VEL3  = 6;
  localparam int OFS_DOUT  = 8;
  localparam int OFS_DIRT  = 10;
  localparam int OFS_STEPT = 11;
  localparam int OFS_PWM   = 12;
  localparam int OFS_DPOL  = 13;
  localparam int OFS_CSUM  = NBYTES_DEF - 1;

  // The watchdog request rides in the high dout byte.
  localparam int OFS_WDT = 9;
  localparam int WDT_BIT = 6;

  // Increment that sticks at the top of the 8-bit range.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/spi_shadow_regfile.sv
// Shadow byte store for one frame plus the running XOR of every byte written since the last clear.
module spi_shadow_regfile
  import spi_frame_commit_pkg::*;
#(
  parameter int NBYTES = OFS_CSUM + 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   wr_en,
  input  logic [4:0]             wr_idx,
  input  logic [7:0]             wr_data,
  output logic [NBYTES-1:0][7:0] mem,
  output logic [7:0]             acc
);

  // Store each accepted byte at its frame position; contents survive until overwritten.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem <= '0;
    end else if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  // Running checksum, restarted at every frame start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= 8'h00;
    end else if (clear) begin
      acc <= 8'h00;
    end else if (wr_en) begin
      acc <= acc ^ wr_data;
    end
  end

endmodule

// File: rtl/spi_frame_commit.sv
// Frame sequencer: collects SPI bytes into a shadow and commits all live registers at once,
// only for complete, in-order frames with a good checksum.
module spi_frame_commit
  import spi_frame_commit_pkg::*;
#(
  parameter int F      = 11,
  parameter int T      = 5,
  parameter int O      = 16,
  parameter int NBYTES = NBYTES_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         frame_start,
  input  logic         frame_end,
  input  logic         byte_valid,
  input  logic [7:0]   byte_data,
  input  logic [4:0]   byte_idx,
  output logic         snap,
  output logic [F:0]   vel0,
  output logic [F:0]   vel1,
  output logic [F:0]   vel2,
  output logic [F:0]   vel3,
  output logic [O-1:0] dout,
  output logic [T-1:0] dirtime,
  output logic [T-1:0] steptime,
  output logic [1:0]   tap,
  output logic         spolarity,
  output logic [3:0]   dpolarity,
  output logic [7:0]   pwm,
  output logic         commit,
  output logic         wdt_kick,
  output logic [7:0]   err_cnt
);

  localparam logic [5:0] NB = 6'(NBYTES);

  logic [1:0]              state;
  logic [1:0]              state_nxt;
  logic [5:0]              count;
  logic [5:0]              count_nxt;
  logic [7:0]              acc;
  logic [7:0]              acc_nxt;
  logic [NBYTES-1:0][7:0]  shadow;
  logic                    in_recv;
  logic                    idx_ok;
  logic                    accept;
  logic                    byte_bad;
  logic                    frame_ok;
  logic                    restart;
  logic                    err_inc;
  logic                    snap_pending;
  logic                    unused_shadow_bits;

  // Reserved bytes and the bits above each field are stored but never decoded.
  assign unused_shadow_bits = ^shadow;

  assign in_recv   = (state == ST_RECV);
  assign idx_ok    = ({1'b0, byte_idx} == count) && (count < NB);
  assign accept    = in_recv && byte_valid && idx_ok && !frame_start;
  assign byte_bad  = in_recv && byte_valid && !idx_ok && !frame_start;
  assign acc_nxt   = accept ? (acc ^ byte_data) : acc;
  assign count_nxt = accept ? (count + 6'd1) : count;
  // A byte arriving with frame_end is counted before the frame is judged.
  assign frame_ok  = !byte_bad && (count_nxt == NB) && (acc_nxt == 8'h00);

  // Snapshot fires with frame_start, or one cycle late if it collided with a commit.
  assign snap = rst_n && ((frame_start && (state != ST_COMMIT)) || snap_pending);

  spi_shadow_regfile #(.NBYTES(NBYTES)) u_shadow (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (restart),
    .wr_en   (accept),
    .wr_idx  (byte_idx),
    .wr_data (byte_data),
    .mem     (shadow),
    .acc     (acc)
  );

  // Next-state decision, frame restarts and error events.
  always_comb begin
    state_nxt = state;
    restart   = 1'b0;
    err_inc   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (frame_start) begin
          state_nxt = ST_RECV;
          restart   = 1'b1;
        end
      end
      ST_RECV: begin
        if (frame_start) begin
          state_nxt = ST_RECV;
          restart   = 1'b1;
          err_inc   = 1'b1;
        end else if (frame_end) begin
          if (frame_ok) begin
            state_nxt = ST_COMMIT;
          end else begin
            state_nxt = ST_IDLE;
            err_inc   = 1'b1;
          end
        end else if (byte_bad) begin
          state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (frame_start) begin
          state_nxt = ST_RECV;
          restart   = 1'b1;
          err_inc   = 1'b1;
        end else if (frame_end) begin
          state_nxt = ST_IDLE;
          err_inc   = 1'b1;
        end
      end
      default: begin
        if (frame_start) begin
          state_nxt = ST_RECV;
          restart   = 1'b1;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
    endcase
  end

  // State register, byte counter and deferred snapshot flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      count        <= 6'd0;
      snap_pending <= 1'b0;
    end else begin
      state        <= state_nxt;
      count        <= restart ? 6'd0 : count_nxt;
      snap_pending <= (state == ST_COMMIT) && frame_start;
    end
  end

  // Rejected-frame counter, saturating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= 8'h00;
    end else if (err_inc) begin
      err_cnt <= sat_inc8(err_cnt);
    end
  end

  // Live registers: all fields load from the shadow together in the commit cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vel0      <= '0;
      vel1      <= '0;
      vel2      <= '0;
      vel3      <= '0;
      dout      <= '0;
      dirtime   <= '0;
      steptime  <= '0;
      tap       <= '0;
      spolarity <= 1'b0;
      dpolarity <= '0;
      pwm       <= '0;
      commit    <= 1'b0;
      wdt_kick  <= 1'b0;
    end else begin
      commit   <= (state == ST_COMMIT);
      wdt_kick <= (state == ST_COMMIT) && shadow[OFS_WDT][WDT_BIT];
      if (state == ST_COMMIT) begin
        vel0      <= {shadow[OFS_VEL0+1][F-8:0], shadow[OFS_VEL0]};
        vel1      <= {shadow[OFS_VEL1+1][F-8:0], shadow[OFS_VEL1]};
        vel2      <= {shadow[OFS_VEL2+1][F-8:0], shadow[OFS_VEL2]};
        vel3      <= {shadow[OFS_VEL3+1][F-8:0], shadow[OFS_VEL3]};
        dout      <= {shadow[OFS_DOUT+1][O-9:0], shadow[OFS_DOUT]};
        spolarity <= shadow[OFS_DIRT][7];
        dirtime   <= shadow[OFS_DIRT][T-1:0];
        tap       <= shadow[OFS_STEPT][7:6];
        steptime  <= shadow[OFS_STEPT][T-1:0];
        pwm       <= shadow[OFS_PWM];
        dpolarity <= shadow[OFS_DPOL][3:0];
      end
    end
  end

endmodule

// File: tb/tb_spi_frame_commit.sv
// Self-checking bench for spi_frame_commit: table of frames plus hand-written corner sequences.
module tb_spi_frame_commit;

  localparam int F      = 11;
  localparam int T      = 5;
  localparam int O      = 16;
  localparam int NBYTES = 21;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         frame_start = 1'b0;
  logic         frame_end = 1'b0;
  logic         byte_valid = 1'b0;
  logic [7:0]   byte_data = 8'h00;
  logic [4:0]   byte_idx = 5'd0;
  logic         snap;
  logic [F:0]   vel0, vel1, vel2, vel3;
  logic [O-1:0] dout;
  logic [T-1:0] dirtime, steptime;
  logic [1:0]   tap;
  logic         spolarity;
  logic [3:0]   dpolarity;
  logic [7:0]   pwm;
  logic         commit, wdt_kick;
  logic [7:0]   err_cnt;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic             commit;
    logic             kick;
    logic [3:0][11:0] vel;
    logic [15:0]      dout;
    logic [4:0]       dirtime;
    logic [4:0]       steptime;
    logic [1:0]       tap;
    logic             spol;
    logic [3:0]       dpol;
    logic [7:0]       pwm;
    logic [7:0]       err;
  } exp_t;

  typedef struct {
    int          n;
    int          flip;
    int          skip;
    logic [11:0] v0;
    logic [15:0] dout;
    logic [7:0]  pwm;
    bit          good;
    bit          kick;
  } vec_t;

  exp_t       mdl;
  exp_t       sb[$];
  logic [7:0] frm [0:21];
  vec_t       vecs [8];

  spi_frame_commit #(.F(F), .T(T), .O(O), .NBYTES(NBYTES)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .frame_end   (frame_end),
    .byte_valid  (byte_valid),
    .byte_data   (byte_data),
    .byte_idx    (byte_idx),
    .snap        (snap),
    .vel0        (vel0),
    .vel1        (vel1),
    .vel2        (vel2),
    .vel3        (vel3),
    .dout        (dout),
    .dirtime     (dirtime),
    .steptime    (steptime),
    .tap         (tap),
    .spolarity   (spolarity),
    .dpolarity   (dpolarity),
    .pwm         (pwm),
    .commit      (commit),
    .wdt_kick    (wdt_kick),
    .err_cnt     (err_cnt)
  );

  always #5 clk = ~clk;

  // Hard stop so the bench can never hang.
  initial begin
    #500000;
    $display("[TB] FAIL timeout actual=running required=finished");
    $fatal(1, "[TB] timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Frame with distinct field contents and a correct checksum in byte NBYTES-1.
  task automatic build_frame(input logic [11:0] v0, input logic [15:0] d,
                             input logic [7:0] p, input int seed);
    logic [7:0] cs;
    frm[0] = v0[7:0];
    frm[1] = {4'hA, v0[11:8]};
    for (int k = 2; k < 8; k++) frm[k] = 8'(seed * 37 + k * 11);
    frm[8]  = d[7:0];
    frm[9]  = d[15:8];
    frm[10] = 8'(seed * 13 + 5);
    frm[11] = 8'(seed * 7 + 145);
    frm[12] = p;
    frm[13] = 8'(seed + 60);
    for (int k = 14; k < NBYTES - 1; k++) frm[k] = 8'(k * seed + 1);
    cs = 8'h00;
    for (int k = 0; k < NBYTES - 1; k++) cs = cs ^ frm[k];
    frm[NBYTES-1] = cs;
    frm[21] = 8'h5A;
  endtask

  // Reference model: advance the expected live state and queue the expectation.
  task automatic model_frame(input bit good, input bit kick);
    exp_t e;
    e = mdl;
    if (good) begin
      for (int v = 0; v < 4; v++) e.vel[v] = {frm[2*v+1][3:0], frm[2*v]};
      e.dout     = {frm[9], frm[8]};
      e.spol     = frm[10][7];
      e.dirtime  = frm[10][4:0];
      e.tap      = frm[11][7:6];
      e.steptime = frm[11][4:0];
      e.pwm      = frm[12];
      e.dpol     = frm[13][3:0];
    end else if (e.err != 8'hFF) begin
      e.err = e.err + 8'd1;
    end
    e.commit = good;
    e.kick   = good && kick;
    mdl = e;
    sb.push_back(e);
  endtask

  task automatic applyStimulus(input int n, input int skip, input bit end_with_last,
                               input bit send_start);
    int idx;
    if (send_start) begin
      frame_start = 1'b1;
      #1;
      chk("snap_on_start", 32'(snap), 32'd1);
      @(posedge clk); #1;
      frame_start = 1'b0;
    end
    idx = 0;
    for (int i = 0; i < n; i++) begin
      if (i == skip) idx++;
      byte_valid = 1'b1;
      byte_data  = frm[i];
      byte_idx   = idx[4:0];
      frame_end  = end_with_last && (i == n - 1);
      @(posedge clk); #1;
      byte_valid = 1'b0;
      frame_end  = 1'b0;
      idx++;
    end
    if (!end_with_last) begin
      frame_end = 1'b1;
      @(posedge clk); #1;
      frame_end = 1'b0;
    end
  endtask

  // Pops the expectation and watches a bounded window after frame_end for the commit pulse.
  task automatic checkOutput(input string name);
    exp_t e;
    int   at;
    logic kick_seen;
    bit   stray;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s_scoreboard actual=empty required=entry", name);
      return;
    end
    e = sb.pop_front();
    at = -1;
    kick_seen = 1'b0;
    stray = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1;
      if (commit) begin
        if (at < 0) begin
          at = c;
          kick_seen = wdt_kick;
        end else begin
          stray = 1'b1;
        end
      end else if (wdt_kick) begin
        stray = 1'b1;
      end
    end
    chk({name, "_commit_cycle"}, 32'(at), e.commit ? 32'd1 : 32'hFFFF_FFFF);
    chk({name, "_kick"}, 32'(kick_seen), 32'(e.kick));
    chk({name, "_stray_pulse"}, 32'(stray), 32'd0);
    chk({name, "_vel0"}, 32'(vel0), 32'(e.vel[0]));
    chk({name, "_vel1"}, 32'(vel1), 32'(e.vel[1]));
    chk({name, "_vel2"}, 32'(vel2), 32'(e.vel[2]));
    chk({name, "_vel3"}, 32'(vel3), 32'(e.vel[3]));
    chk({name, "_dout"}, 32'(dout), 32'(e.dout));
    chk({name, "_dirtime"}, 32'(dirtime), 32'(e.dirtime));
    chk({name, "_steptime"}, 32'(steptime), 32'(e.steptime));
    chk({name, "_tap"}, 32'(tap), 32'(e.tap));
    chk({name, "_spol"}, 32'(spolarity), 32'(e.spol));
    chk({name, "_dpol"}, 32'(dpolarity), 32'(e.dpol));
    chk({name, "_pwm"}, 32'(pwm), 32'(e.pwm));
    chk({name, "_err_cnt"}, 32'(err_cnt), 32'(e.err));
  endtask

  initial begin
    exp_t e;
    mdl = '0;
    vecs[0] = '{21, -1, -1, 12'h123, 16'hA55A, 8'h80, 1'b1, 1'b0};
    vecs[1] = '{21,  5, -1, 12'h123, 16'hA55A, 8'h80, 1'b0, 1'b0};
    vecs[2] = '{10, -1, -1, 12'h2AA, 16'h1111, 8'h10, 1'b0, 1'b0};
    vecs[3] = '{21, -1, -1, 12'hFFF, 16'h0001, 8'hFF, 1'b1, 1'b0};
    vecs[4] = '{21, -1,  4, 12'h555, 16'h2222, 8'h20, 1'b0, 1'b0};
    vecs[5] = '{22, -1, -1, 12'h0F0, 16'h3333, 8'h30, 1'b0, 1'b0};
    vecs[6] = '{21, -1, -1, 12'h7E1, 16'h40C3, 8'h01, 1'b1, 1'b1};
    vecs[7] = '{21, -1, -1, 12'h018, 16'hBF00, 8'h7F, 1'b1, 1'b0};

    #1;
    chk("reset_vel0", 32'(vel0), 32'd0);
    chk("reset_dout", 32'(dout), 32'd0);
    chk("reset_pwm", 32'(pwm), 32'd0);
    chk("reset_err_cnt", 32'(err_cnt), 32'd0);
    chk("reset_commit", 32'(commit), 32'd0);
    chk("reset_snap", 32'(snap), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      build_frame(vecs[i].v0, vecs[i].dout, vecs[i].pwm, i + 1);
      if (vecs[i].flip >= 0) frm[vecs[i].flip] = frm[vecs[i].flip] ^ 8'h10;
      model_frame(vecs[i].good, vecs[i].kick);
      applyStimulus(vecs[i].n, vecs[i].skip, 1'b0, 1'b1);
      checkOutput($sformatf("vec%0d", i));
      if (vecs[i].good) begin
        chk($sformatf("vec%0d_vel0_table", i), 32'(vel0), 32'(vecs[i].v0));
        chk($sformatf("vec%0d_dout_table", i), 32'(dout), 32'(vecs[i].dout));
        chk($sformatf("vec%0d_pwm_table", i), 32'(pwm), 32'(vecs[i].pwm));
      end
      @(posedge clk); #1;
    end
    chk("err_after_table", 32'(err_cnt), 32'd4);

    // Last byte and frame_end in the same cycle still commit.
    build_frame(12'h456, 16'h1234, 8'h22, 11);
    model_frame(1'b1, 1'b0);
    applyStimulus(NBYTES, -1, 1'b1, 1'b1);
    checkOutput("same_cycle_end");

    // frame_start during the commit cycle: commit completes, snap comes one cycle later.
    build_frame(12'h0AB, 16'h00FF, 8'h33, 12);
    model_frame(1'b1, 1'b0);
    applyStimulus(NBYTES, -1, 1'b0, 1'b1);
    frame_start = 1'b1;
    #1;
    chk("snap_in_commit", 32'(snap), 32'd0);
    @(posedge clk); #1;
    frame_start = 1'b0;
    chk("snap_delayed", 32'(snap), 32'd1);
    e = sb.pop_front();
    chk("commit_with_start", 32'(commit), 32'd1);
    chk("vel0_with_start", 32'(vel0), 32'(e.vel[0]));
    chk("err_with_start", 32'(err_cnt), 32'(e.err));
    @(posedge clk); #1;
    chk("snap_single", 32'(snap), 32'd0);
    build_frame(12'hBCD, 16'h4321, 8'h44, 13);
    model_frame(1'b1, 1'b1);
    applyStimulus(NBYTES, -1, 1'b0, 1'b0);
    checkOutput("after_commit_start");

    // Restart mid-frame aborts the partial frame and counts an error.
    build_frame(12'h321, 16'h0F0F, 8'h55, 14);
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      byte_valid = 1'b1;
      byte_data  = frm[i];
      byte_idx   = 5'(i);
      @(posedge clk); #1;
      byte_valid = 1'b0;
    end
    if (mdl.err != 8'hFF) mdl.err = mdl.err + 8'd1;
    model_frame(1'b1, 1'b0);
    applyStimulus(NBYTES, -1, 1'b0, 1'b1);
    checkOutput("abort_restart");

    // Reset in the middle of a frame clears everything without a clock edge.
    build_frame(12'h999, 16'h7777, 8'h99, 15);
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      byte_valid = 1'b1;
      byte_data  = frm[i];
      byte_idx   = 5'(i);
      @(posedge clk); #1;
      byte_valid = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    chk("midreset_vel0", 32'(vel0), 32'd0);
    chk("midreset_dout", 32'(dout), 32'd0);
    chk("midreset_pwm", 32'(pwm), 32'd0);
    chk("midreset_tap", 32'(tap), 32'd0);
    chk("midreset_err_cnt", 32'(err_cnt), 32'd0);
    mdl = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Many empty frames drive the error counter into saturation.
    for (int i = 0; i < 260; i++) begin
      frame_start = 1'b1;
      @(posedge clk); #1;
      frame_start = 1'b0;
      frame_end = 1'b1;
      @(posedge clk); #1;
      frame_end = 1'b0;
      if (mdl.err != 8'hFF) mdl.err = mdl.err + 8'd1;
    end
    chk("err_saturated", 32'(err_cnt), 32'h0000_00FF);
    chk("err_model", 32'(err_cnt), 32'(mdl.err));
    chk("sat_vel0_held", 32'(vel0), 32'd0);
    build_frame(12'h777, 16'h8001, 8'h66, 16);
    model_frame(1'b1, 1'b0);
    applyStimulus(NBYTES, -1, 1'b0, 1'b1);
    checkOutput("post_saturation");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
